event_fifo_arbiter: RTL and testbench
=====================================

Name: event_fifo_arbiter

Overview:
- Round-robin arbiter that drains several 128-bit event FIFOs into one registered 128-bit output stream with a valid/ready handshake. Sources include the prime/alive status FIFO and sibling monitor FIFOs.
- Sits between the monitor blocks and the host telemetry path.
- Issues single-cycle FIFO reads, captures the data one cycle later and tags it with the source index.
- Supports bounded per-source bursts so that no source is starved.

Parameters:
NUM_SRC, 4, number of source FIFOs (2..8)
DATA_W, 128, FIFO word width
SRC_W, 3, width of source index tag (ceil log2 NUM_SRC, min 1)
MAX_BURST, 4, max words drained from one source per grant (1..255)

Ports:
CLK  in  1  system clock, 10 MHz
RESET  in  1  asynchronous, active-high reset
SRC_EMPTY  in  NUM_SRC  per-source FIFO empty flag
SRC_DATA  in  NUM_SRC*DATA_W  flattened FIFO dout; source i occupies bits [i*DATA_W +: DATA_W]
SRC_READ  out  NUM_SRC  per-source rd_en, at most one bit high per cycle
OUT_DATA  out  DATA_W  registered output word
OUT_SRC  out  SRC_W  source index of OUT_DATA
OUT_VALID  out  1  OUT_DATA/OUT_SRC valid
OUT_READY  in  1  downstream accept
BUSY  out  1  high in any state other than IDLE
WORD_COUNT  out  32  total words delivered, wraps at 2^32

Behaviour:
- Reset is asynchronous, active-high; clock is CLK. Reset values:
  - SRC_READ=0, OUT_VALID=0, OUT_DATA=0, OUT_SRC=0, BUSY=0, WORD_COUNT=0.
  - Round-robin pointer ptr=0, burst_cnt=0, state=IDLE.
- FIFO model: standard (non-FWFT) FIFO. Data appears on SRC_DATA one cycle after SRC_READ is sampled high. SRC_EMPTY is valid and settled one cycle after a read.
- States: IDLE, READ, CAPTURE, HOLD.
- IDLE:
  - If any SRC_EMPTY bit is 0, grant g = first non-empty index searching ptr, ptr+1, ..., wrapping modulo NUM_SRC.
  - Register g, clear burst_cnt, go to READ. Otherwise stay in IDLE.
- READ:
  - SRC_READ[g]=1 for exactly this one cycle; go to CAPTURE.
  - The read is issued only if SRC_EMPTY[g]=0 in this cycle. Otherwise no read, ptr=g+1 mod NUM_SRC, go to IDLE (defensive).
- CAPTURE:
  - On the clock edge leaving CAPTURE: OUT_DATA <= SRC_DATA[g], OUT_SRC <= g, OUT_VALID <= 1, go to HOLD.
- HOLD:
  - OUT_VALID stays high; OUT_DATA and OUT_SRC are stable until OUT_READY=1.
  - On the handshake edge: OUT_VALID <= 0, WORD_COUNT += 1, burst_cnt += 1.
    - If burst_cnt+1 < MAX_BURST and SRC_EMPTY[g]=0: go to READ with the same g.
    - Otherwise: ptr <= g+1 mod NUM_SRC, go to IDLE.
- Throughput and latency:
  - Burst words: one word per 3 cycles with OUT_READY tied high.
  - IDLE-to-OUT_VALID latency: 3 cycles (IDLE, READ, CAPTURE).
- No word loss or duplication: each SRC_READ pulse yields exactly one OUT_VALID word.
- SRC_EMPTY changes while in CAPTURE or HOLD are ignored until the HOLD exit decision.
- Sources becoming non-empty during a burst wait for round-robin order; there is no priority preemption.
- NUM_SRC=1: ptr is always 0; bursts repeat back-to-back through IDLE.
- Reset mid-operation: immediate return to reset values. A word read but not yet delivered is lost; the monitors tolerate this.
- OUT_READY asserted while OUT_VALID=0 is ignored.

Decomposition:
- Shared package:
  - State encoding constants (IDLE=2'd0, READ=2'd1, CAPTURE=2'd2, HOLD=2'd3).
  - DATA_W default and the NUM_SRC to SRC_W relation.
- One natural sub-module: rr_pick, a combinational round-robin first-one finder.
  - Inputs: request vector = ~SRC_EMPTY, and ptr.
  - Outputs: grant index and any_req.
  - Reusable by other host-bus arbiters.

Test Plan:
- Single source: source 2 holds 1 word (0x...A5), OUT_READY=1 → SRC_READ[2] pulses once; OUT_VALID 3 cycles after SRC_EMPTY[2] falls; OUT_SRC=2; WORD_COUNT=1; BUSY returns to 0.
- Round-robin fairness: all 4 sources hold 10 words, MAX_BURST=4 → OUT_SRC sequence 0,0,0,0,1,1,1,1,2,... with ptr rotation; 40 words delivered in order per source.
- Backpressure: OUT_READY held 0 for 20 cycles → OUT_VALID stays high, data stable, no further SRC_READ; release → exactly one handshake, WORD_COUNT increments by 1.
- Wrap: ptr=3, sources 0 and 3 non-empty → source 3 granted first, then source 0.
- Burst cut short: source 1 has 2 words, MAX_BURST=4 → 2 words delivered, then IDLE with ptr=2.
- Reset during HOLD: assert RESET → OUT_VALID=0, SRC_READ=0, WORD_COUNT=0 immediately. After release, arbitration restarts at ptr=0.

Source files
------------

// File: rtl/event_fifo_arbiter_pkg.sv
// Shared types and constants for the event FIFO arbiter and its round-robin picker.
package event_fifo_arbiter_pkg;

  localparam int DEFAULT_DATA_W  = 128;
  localparam int DEFAULT_NUM_SRC = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } arb_state_e;

  // Smallest source-index width able to name every source (never below 1).
  function automatic int src_w_for(input int num_src);
    return (num_src <= 2) ? 1 : $clog2(num_src);
  endfunction

endpackage

// File: rtl/event_fifo_arbiter_rr_pick.sv
// Combinational round-robin first-one finder: returns the first requesting index
// at or after i_ptr, wrapping modulo N.
module event_fifo_arbiter_rr_pick
  import event_fifo_arbiter_pkg::*;
#(
  parameter int N     = DEFAULT_NUM_SRC,
  parameter int IDX_W = src_w_for(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_grant,
  output logic             o_any_req
);

  logic [N-1:0] w_rot;
  int           w_offset;
  int           w_sum;

  // Rotating the doubled request vector puts index i_ptr at bit 0.
  assign w_rot     = N'({i_req, i_req} >> i_ptr);
  assign o_any_req = |i_req;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which is what would otherwise infer a latch.
  always_comb begin
    w_offset = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_offset = k;
    end
    w_sum = int'(i_ptr) + w_offset;
    if (w_sum >= N) w_sum = w_sum - N;
    o_grant = IDX_W'(w_sum);
  end

endmodule

// File: rtl/event_fifo_arbiter.sv
// Round-robin drain of several non-FWFT event FIFOs into one registered,
// source-tagged valid/ready stream with bounded per-source bursts.
module event_fifo_arbiter
  import event_fifo_arbiter_pkg::*;
#(
  parameter int NUM_SRC   = DEFAULT_NUM_SRC,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int SRC_W     = 3,
  parameter int MAX_BURST = 4
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [NUM_SRC-1:0]        SRC_EMPTY,
  input  logic [NUM_SRC*DATA_W-1:0] SRC_DATA,
  output logic [NUM_SRC-1:0]        SRC_READ,
  output logic [DATA_W-1:0]         OUT_DATA,
  output logic [SRC_W-1:0]          OUT_SRC,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic                      BUSY,
  output logic [31:0]               WORD_COUNT
);

  arb_state_e         r_state;
  arb_state_e         w_next_state;
  logic [SRC_W-1:0]   r_ptr;
  logic [SRC_W-1:0]   r_grant;
  logic [7:0]         r_burst_cnt;
  logic [DATA_W-1:0]  r_out_data;
  logic [SRC_W-1:0]   r_out_src;
  logic               r_out_valid;
  logic [31:0]        r_word_count;

  logic [SRC_W-1:0]   w_pick;
  logic               w_any_req;
  logic [NUM_SRC-1:0] w_grant_oh;
  logic               w_grant_empty;
  logic [DATA_W-1:0]  w_sel_data;
  logic [SRC_W-1:0]   w_next_ptr;
  logic               w_burst_more;
  logic               w_burst_go;

  event_fifo_arbiter_rr_pick #(
    .N     (NUM_SRC),
    .IDX_W (SRC_W)
  ) u_rr_pick (
    .i_req     (~SRC_EMPTY),
    .i_ptr     (r_ptr),
    .o_grant   (w_pick),
    .o_any_req (w_any_req)
  );

  assign w_grant_oh    = NUM_SRC'(1) << r_grant;
  assign w_grant_empty = |(SRC_EMPTY & w_grant_oh);
  assign w_next_ptr    = (r_grant == SRC_W'(NUM_SRC - 1)) ? '0 : r_grant + SRC_W'(1);
  assign w_burst_more  = ({1'b0, r_burst_cnt} + 9'd1) < 9'(MAX_BURST);
  assign w_burst_go    = w_burst_more && !w_grant_empty;

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_grant_oh[i]) w_sel_data = SRC_DATA[i*DATA_W +: DATA_W];
    end
  end

  // A read is only issued against a source that is still non-empty.
  assign SRC_READ   = (r_state == READ && !w_grant_empty) ? w_grant_oh : '0;
  assign OUT_DATA   = r_out_data;
  assign OUT_SRC    = r_out_src;
  assign OUT_VALID  = r_out_valid;
  assign BUSY       = (r_state != IDLE);
  assign WORD_COUNT = r_word_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next_state = READ;
      READ:    w_next_state = w_grant_empty ? IDLE : CAPTURE;
      CAPTURE: w_next_state = HOLD;
      HOLD:    if (OUT_READY) w_next_state = w_burst_go ? READ : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ptr        <= '0;
      r_grant      <= '0;
      r_burst_cnt  <= '0;
      r_out_data   <= '0;
      r_out_src    <= '0;
      r_out_valid  <= 1'b0;
      r_word_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant     <= w_pick;
            r_burst_cnt <= '0;
          end
        end
        READ: begin
          if (w_grant_empty) r_ptr <= w_next_ptr;
        end
        CAPTURE: begin
          r_out_data  <= w_sel_data;
          r_out_src   <= r_grant;
          r_out_valid <= 1'b1;
        end
        HOLD: begin
          // Source emptiness is only consulted here, at the burst-continue decision.
          if (OUT_READY) begin
            r_out_valid  <= 1'b0;
            r_word_count <= r_word_count + 32'd1;
            r_burst_cnt  <= r_burst_cnt + 8'd1;
            if (!w_burst_go) r_ptr <= w_next_ptr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_event_fifo_arbiter.sv
// Directed bench for event_fifo_arbiter: queue-based non-FWFT FIFO models,
// a handshake monitor, and one task per scenario.
module tb_event_fifo_arbiter;

  localparam int NUM_SRC   = 4;
  localparam int DATA_W    = 128;
  localparam int SRC_W     = 3;
  localparam int MAX_BURST = 4;

  logic                      CLK = 1'b0;
  logic                      RESET;
  logic [NUM_SRC-1:0]        SRC_EMPTY;
  logic [NUM_SRC*DATA_W-1:0] SRC_DATA;
  logic [NUM_SRC-1:0]        SRC_READ;
  logic [DATA_W-1:0]         OUT_DATA;
  logic [SRC_W-1:0]          OUT_SRC;
  logic                      OUT_VALID;
  logic                      OUT_READY;
  logic                      BUSY;
  logic [31:0]               WORD_COUNT;

  event_fifo_arbiter #(
    .NUM_SRC   (NUM_SRC),
    .DATA_W    (DATA_W),
    .SRC_W     (SRC_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .SRC_EMPTY  (SRC_EMPTY),
    .SRC_DATA   (SRC_DATA),
    .SRC_READ   (SRC_READ),
    .OUT_DATA   (OUT_DATA),
    .OUT_SRC    (OUT_SRC),
    .OUT_VALID  (OUT_VALID),
    .OUT_READY  (OUT_READY),
    .BUSY       (BUSY),
    .WORD_COUNT (WORD_COUNT)
  );

  always #50 CLK = ~CLK;

  // FIFO models: data one cycle after a sampled read, empty refreshed each negedge.
  logic [DATA_W-1:0] fifo_q    [NUM_SRC][$];
  logic [DATA_W-1:0] fifo_dout [NUM_SRC];
  int                underflow = 0;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_dout
    assign SRC_DATA[g*DATA_W +: DATA_W] = fifo_dout[g];
  end

  always @(posedge CLK) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (SRC_READ[i]) begin
        if (fifo_q[i].size() > 0) fifo_dout[i] <= fifo_q[i].pop_front();
        else                      underflow <= underflow + 1;
      end
    end
  end

  always @(negedge CLK) begin
    for (int i = 0; i < NUM_SRC; i++) SRC_EMPTY[i] <= (fifo_q[i].size() == 0);
  end

  // Monitor: records each accepted word and counts read pulses.
  typedef struct {
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
    int                cyc;
  } rx_t;

  rx_t rx_q[$];
  int  cyc_cnt  = 0;
  int  rd_total = 0;
  int  multi_rd = 0;
  int  rd_per [NUM_SRC];

  always @(negedge CLK) begin
    cyc_cnt <= cyc_cnt + 1;
    if (!RESET) begin
      if (OUT_VALID && OUT_READY) rx_q.push_back('{src: OUT_SRC, data: OUT_DATA, cyc: cyc_cnt});
      rd_total <= rd_total + $countones(SRC_READ);
      if ($countones(SRC_READ) > 1) multi_rd <= multi_rd + 1;
      for (int i = 0; i < NUM_SRC; i++) rd_per[i] <= rd_per[i] + int'(SRC_READ[i]);
    end
  end

  int vectors     = 0;
  int miscompares = 0;
  int rx_rd       = 0;
  int next_k [NUM_SRC];
  int exp_k  [NUM_SRC];

  function automatic logic [DATA_W-1:0] word(input int s, input int k);
    return {8'(s), 16'(k), 96'h0123_4567_89AB_CDEF_0011_2233, 8'hA5};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic load(input int s, input int n);
    for (int j = 0; j < n; j++) begin
      fifo_q[s].push_back(word(s, next_k[s]));
      next_k[s]++;
    end
  endtask

  task automatic wait_words(input int n, input int budget);
    int t;
    t = 0;
    while (rx_q.size() < rx_rd + n && t < budget) begin
      tick();
      t++;
    end
    if (rx_q.size() < rx_rd + n) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_words: got %0d words, required %0d", rx_q.size() - rx_rd, n);
    end
  endtask

  task automatic wait_valid(input int budget);
    int t;
    t = 0;
    while (OUT_VALID !== 1'b1 && t < budget) begin
      tick();
      t++;
    end
    if (OUT_VALID !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_valid: OUT_VALID never rose within %0d cycles", budget);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    RESET     = 1'b1;
    OUT_READY = 1'b0;
    repeat (3) tick();
    vectors += 6;
    if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL reset OUT_VALID: got %b, required 0", OUT_VALID); end
    if (OUT_DATA !== '0) begin miscompares++; $display("FAIL reset OUT_DATA: got %h, required 0", OUT_DATA); end
    if (OUT_SRC !== '0) begin miscompares++; $display("FAIL reset OUT_SRC: got %0d, required 0", OUT_SRC); end
    if (BUSY !== 1'b0) begin miscompares++; $display("FAIL reset BUSY: got %b, required 0", BUSY); end
    if (WORD_COUNT !== 32'd0) begin miscompares++; $display("FAIL reset WORD_COUNT: got %0d, required 0", WORD_COUNT); end
    if (SRC_READ !== '0) begin miscompares++; $display("FAIL reset SRC_READ: got %b, required 0000", SRC_READ); end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_single_source();
    rx_rd     = rx_q.size();
    OUT_READY = 1'b1;
    load(2, 1);
    tick();
    vectors += 3;
    if (BUSY !== 1'b1) begin miscompares++; $display("FAIL single READ BUSY: got %b, required 1", BUSY); end
    if (SRC_READ !== 4'b0100) begin miscompares++; $display("FAIL single SRC_READ: got %b, required 0100", SRC_READ); end
    if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL single early valid (READ): got %b, required 0", OUT_VALID); end
    tick();
    vectors += 2;
    if (SRC_READ !== 4'b0000) begin miscompares++; $display("FAIL single read pulse width: got %b, required 0000", SRC_READ); end
    if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL single early valid (CAPTURE): got %b, required 0", OUT_VALID); end
    tick();
    vectors += 3;
    if (OUT_VALID !== 1'b1) begin miscompares++; $display("FAIL single latency valid: got %b, required 1", OUT_VALID); end
    if (OUT_SRC !== 3'd2) begin miscompares++; $display("FAIL single OUT_SRC: got %0d, required 2", OUT_SRC); end
    if (OUT_DATA !== word(2, 0)) begin miscompares++; $display("FAIL single OUT_DATA: got %h, required %h", OUT_DATA, word(2, 0)); end
    tick();
    vectors += 4;
    if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL single valid drop: got %b, required 0", OUT_VALID); end
    if (WORD_COUNT !== 32'd1) begin miscompares++; $display("FAIL single WORD_COUNT: got %0d, required 1", WORD_COUNT); end
    if (BUSY !== 1'b0) begin miscompares++; $display("FAIL single BUSY idle: got %b, required 0", BUSY); end
    if (rd_per[2] !== 1) begin miscompares++; $display("FAIL single read count: got %0d, required 1", rd_per[2]); end
    exp_k[2]++;
    rx_rd = rx_q.size();
  endtask

  task automatic test_round_robin();
    int es[$];
    int rem [NUM_SRC];
    int n, base;
    do_reset();
    vectors++;
    if (WORD_COUNT !== 32'd0) begin miscompares++; $display("FAIL rr WORD_COUNT after reset: got %0d, required 0", WORD_COUNT); end
    rx_rd     = rx_q.size();
    base      = rx_rd;
    OUT_READY = 1'b1;
    for (int s = 0; s < NUM_SRC; s++) begin
      load(s, 10);
      rem[s] = 10;
    end
    // Every source stays non-empty until its last word, so bursts rotate 0,1,2,3.
    while (rem[0] + rem[1] + rem[2] + rem[3] > 0) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        n = (rem[s] < MAX_BURST) ? rem[s] : MAX_BURST;
        for (int j = 0; j < n; j++) es.push_back(s);
        rem[s] -= n;
      end
    end
    wait_words(40, 600);
    for (int j = 0; j < es.size(); j++) begin
      vectors++;
      if (rx_rd >= rx_q.size()) begin
        miscompares++;
        $display("FAIL rr word %0d: missing, required src %0d", j, es[j]);
      end else begin
        if (rx_q[rx_rd].src !== SRC_W'(es[j]) || rx_q[rx_rd].data !== word(es[j], exp_k[es[j]])) begin
          miscompares++;
          $display("FAIL rr word %0d: got src %0d data %h, required src %0d data %h",
                   j, rx_q[rx_rd].src, rx_q[rx_rd].data, es[j], word(es[j], exp_k[es[j]]));
        end
        rx_rd++;
      end
      exp_k[es[j]]++;
    end
    if (rx_q.size() >= base + 5) begin
      vectors += 2;
      if (rx_q[base+1].cyc - rx_q[base].cyc !== 3) begin
        miscompares++; $display("FAIL rr in-burst spacing: got %0d cycles, required 3", rx_q[base+1].cyc - rx_q[base].cyc);
      end
      if (rx_q[base+4].cyc - rx_q[base+3].cyc !== 4) begin
        miscompares++; $display("FAIL rr burst-boundary spacing: got %0d cycles, required 4", rx_q[base+4].cyc - rx_q[base+3].cyc);
      end
    end
    tick();
    vectors += 2;
    if (WORD_COUNT !== 32'd40) begin miscompares++; $display("FAIL rr WORD_COUNT: got %0d, required 40", WORD_COUNT); end
    if (BUSY !== 1'b0) begin miscompares++; $display("FAIL rr BUSY after drain: got %b, required 0", BUSY); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] held;
    int rd0;
    OUT_READY = 1'b0;
    load(0, 1);
    wait_valid(10);
    load(3, 1);
    held = OUT_DATA;
    rd0  = rd_total;
    vectors++;
    if (held !== word(0, exp_k[0])) begin miscompares++; $display("FAIL bp OUT_DATA: got %h, required %h", held, word(0, exp_k[0])); end
    for (int c = 0; c < 20; c++) begin
      tick();
      vectors++;
      if (OUT_VALID !== 1'b1 || OUT_DATA !== held || OUT_SRC !== 3'd0) begin
        miscompares++;
        $display("FAIL bp hold cycle %0d: got valid %b src %0d data %h, required 1/0/%h", c, OUT_VALID, OUT_SRC, OUT_DATA, held);
      end
    end
    vectors++;
    if (rd_total !== rd0) begin miscompares++; $display("FAIL bp extra reads: got %0d, required 0", rd_total - rd0); end
    rx_rd     = rx_q.size();
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    vectors += 3;
    if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL bp valid after accept: got %b, required 0", OUT_VALID); end
    if (WORD_COUNT !== 32'd41) begin miscompares++; $display("FAIL bp WORD_COUNT: got %0d, required 41", WORD_COUNT); end
    if (rx_q.size() - rx_rd !== 1) begin miscompares++; $display("FAIL bp handshakes: got %0d, required 1", rx_q.size() - rx_rd); end
    rx_rd = rx_q.size();
    exp_k[0]++;
    OUT_READY = 1'b1;
    wait_words(1, 20);
    vectors++;
    if (rx_rd >= rx_q.size() || rx_q[rx_rd].src !== 3'd3 || rx_q[rx_rd].data !== word(3, exp_k[3])) begin
      miscompares++;
      $display("FAIL bp follow-on word: required src 3 data %h", word(3, exp_k[3]));
    end
    exp_k[3]++;
    rx_rd = rx_q.size();
  endtask

  task automatic test_burst_cut();
    int es[$];
    OUT_READY = 1'b1;
    load(1, 2);
    wait_words(2, 30);
    tick();
    vectors++;
    if (BUSY !== 1'b0) begin miscompares++; $display("FAIL cut BUSY: got %b, required 0", BUSY); end
    load(1, 1);
    load(2, 1);
    wait_words(4, 40);
    es = '{1, 1, 2, 1};
    for (int j = 0; j < es.size(); j++) begin
      vectors++;
      if (rx_rd >= rx_q.size()) begin
        miscompares++;
        $display("FAIL cut word %0d: missing, required src %0d", j, es[j]);
      end else begin
        if (rx_q[rx_rd].src !== SRC_W'(es[j]) || rx_q[rx_rd].data !== word(es[j], exp_k[es[j]])) begin
          miscompares++;
          $display("FAIL cut word %0d: got src %0d data %h, required src %0d data %h",
                   j, rx_q[rx_rd].src, rx_q[rx_rd].data, es[j], word(es[j], exp_k[es[j]]));
        end
        rx_rd++;
      end
      exp_k[es[j]]++;
    end
  endtask

  task automatic test_wrap();
    int es[$];
    OUT_READY = 1'b1;
    load(2, 1);
    wait_words(1, 20);
    tick();
    load(0, 1);
    load(3, 1);
    wait_words(3, 40);
    es = '{2, 3, 0};
    for (int j = 0; j < es.size(); j++) begin
      vectors++;
      if (rx_rd >= rx_q.size()) begin
        miscompares++;
        $display("FAIL wrap word %0d: missing, required src %0d", j, es[j]);
      end else begin
        if (rx_q[rx_rd].src !== SRC_W'(es[j]) || rx_q[rx_rd].data !== word(es[j], exp_k[es[j]])) begin
          miscompares++;
          $display("FAIL wrap word %0d: got src %0d data %h, required src %0d data %h",
                   j, rx_q[rx_rd].src, rx_q[rx_rd].data, es[j], word(es[j], exp_k[es[j]]));
        end
        rx_rd++;
      end
      exp_k[es[j]]++;
    end
  endtask

  task automatic test_reset_hold();
    int es[$];
    OUT_READY = 1'b0;
    load(1, 1);
    wait_valid(10);
    vectors++;
    if (OUT_SRC !== 3'd1) begin miscompares++; $display("FAIL rst-hold OUT_SRC before reset: got %0d, required 1", OUT_SRC); end
    RESET = 1'b1;
    #1;
    vectors += 4;
    if (OUT_VALID !== 1'b0) begin miscompares++; $display("FAIL rst-hold OUT_VALID: got %b, required 0", OUT_VALID); end
    if (SRC_READ !== '0) begin miscompares++; $display("FAIL rst-hold SRC_READ: got %b, required 0000", SRC_READ); end
    if (WORD_COUNT !== 32'd0) begin miscompares++; $display("FAIL rst-hold WORD_COUNT: got %0d, required 0", WORD_COUNT); end
    if (BUSY !== 1'b0) begin miscompares++; $display("FAIL rst-hold BUSY: got %b, required 0", BUSY); end
    tick();
    RESET = 1'b0;
    tick();
    exp_k[1]++;
    rx_rd     = rx_q.size();
    OUT_READY = 1'b1;
    load(0, 1);
    load(1, 1);
    wait_words(2, 30);
    es = '{0, 1};
    for (int j = 0; j < es.size(); j++) begin
      vectors++;
      if (rx_rd >= rx_q.size()) begin
        miscompares++;
        $display("FAIL rst-hold word %0d: missing, required src %0d", j, es[j]);
      end else begin
        if (rx_q[rx_rd].src !== SRC_W'(es[j]) || rx_q[rx_rd].data !== word(es[j], exp_k[es[j]])) begin
          miscompares++;
          $display("FAIL rst-hold word %0d: got src %0d data %h, required src %0d data %h",
                   j, rx_q[rx_rd].src, rx_q[rx_rd].data, es[j], word(es[j], exp_k[es[j]]));
        end
        rx_rd++;
      end
      exp_k[es[j]]++;
    end
    tick();
    vectors++;
    if (WORD_COUNT !== 32'd2) begin miscompares++; $display("FAIL rst-hold WORD_COUNT after restart: got %0d, required 2", WORD_COUNT); end
  endtask

  task automatic test_integrity();
    vectors += 3;
    if (multi_rd !== 0) begin miscompares++; $display("FAIL integrity multi-read cycles: got %0d, required 0", multi_rd); end
    if (underflow !== 0) begin miscompares++; $display("FAIL integrity reads of empty FIFO: got %0d, required 0", underflow); end
    // One word was read and then discarded by the mid-HOLD reset.
    if (rd_total !== rx_q.size() + 1) begin
      miscompares++; $display("FAIL integrity reads vs words: got %0d reads, required %0d", rd_total, rx_q.size() + 1);
    end
  endtask

  initial begin
    RESET     = 1'b1;
    OUT_READY = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      next_k[i] = 0;
      exp_k[i]  = 0;
      rd_per[i] = 0;
    end
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_burst_cut();
    test_wrap();
    test_reset_hold();
    test_integrity();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
